// File: rtl/pipe_net_n_if.sv
// rtl/pipe_net_n_if.sv - PipeIn ingress/egress/control bundle for pipe_net_n
interface pipe_net_n_if #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(CHANNELS)
);
    logic [CHANNELS-1:0]            in_enq__ENA;
    logic [CHANNELS*DATA_WIDTH-1:0] in_enq_v;
    logic [CHANNELS-1:0]            in_enq__RDY;
    logic [CHANNELS-1:0]            out_enq__ENA;
    logic [CHANNELS*DATA_WIDTH-1:0] out_enq_v;
    logic [CHANNELS-1:0]            out_enq__RDY;
    logic                           pause__ENA;
    logic                           pause__RDY;
    logic                           cfg_route__ENA;
    logic [CHANNELS*IDX_W-1:0]      cfg_route_v;
    logic                           cfg_route__RDY;

    modport slave (
        input  in_enq__ENA, in_enq_v, out_enq__RDY, pause__ENA, cfg_route__ENA, cfg_route_v,
        output in_enq__RDY, out_enq__ENA, out_enq_v, pause__RDY, cfg_route__RDY
    );

    modport master (
        output in_enq__ENA, in_enq_v, out_enq__RDY, pause__ENA, cfg_route__ENA, cfg_route_v,
        input  in_enq__RDY, out_enq__ENA, out_enq_v, pause__RDY, cfg_route__RDY
    );
endinterface

// File: rtl/pipe_net_n.sv
// rtl/pipe_net_n.sv - N-channel PipeIn fabric: ingress skids, round-robin per egress, egress FIFOs
module pipe_net_n #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CROSSED    = 0
) (
    input  logic         CLK,
    input  logic         nRST,
    pipe_net_n_if.slave  bus
);
    localparam int IDX_W = $clog2(CHANNELS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W:0]   CH_W1     = (IDX_W+1)'(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_IDLE = 2'd2} state_t;
    state_t r_state, w_state_nxt;

    logic [CHANNELS-1:0]   r_skid_vld;
    logic [DATA_WIDTH-1:0] r_skid_data [CHANNELS];
    logic [IDX_W-1:0]      r_dest      [CHANNELS];
    logic [IDX_W-1:0]      r_rr        [CHANNELS];
    logic [DATA_WIDTH-1:0] r_mem       [CHANNELS][DEPTH];
    logic [PTR_W-1:0]      r_wp        [CHANNELS];
    logic [PTR_W-1:0]      r_rp        [CHANNELS];
    logic [CNT_W-1:0]      r_cnt       [CHANNELS];

    logic [CHANNELS-1:0] w_accept, w_take, w_gnt_vld, w_pop;
    logic [IDX_W-1:0]    w_gnt_idx [CHANNELS];
    logic [IDX_W-1:0]    w_route   [CHANNELS];
    logic [IDX_W:0]      w_sum;
    logic [IDX_W-1:0]    w_cand;
    logic                w_all_empty;

    assign bus.in_enq__RDY    = ~r_skid_vld & {CHANNELS{r_state == ST_RUN}};
    assign bus.pause__RDY     = (r_state == ST_RUN);
    assign bus.cfg_route__RDY = (r_state == ST_IDLE);
    assign w_accept           = bus.in_enq__ENA & bus.in_enq__RDY;

    // Cyclic search from rr pointer; a skid has one destination so at most one egress takes it.
    always_comb begin
        w_gnt_vld = '0;
        w_take    = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            w_gnt_idx[j] = '0;
            if (r_cnt[j] != CNT_DEPTH) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    w_sum  = {1'b0, r_rr[j]} + (IDX_W+1)'(k);
                    w_cand = (w_sum >= CH_W1) ? IDX_W'(w_sum - CH_W1) : IDX_W'(w_sum);
                    if (!w_gnt_vld[j] && r_skid_vld[w_cand] && r_dest[w_cand] == IDX_W'(j)) begin
                        w_gnt_vld[j]   = 1'b1;
                        w_gnt_idx[j]   = w_cand;
                        w_take[w_cand] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_all_empty = (r_skid_vld == '0);
        w_pop       = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            w_pop[j] = (r_cnt[j] != '0) && bus.out_enq__RDY[j];
            if (r_cnt[j] != '0) w_all_empty = 1'b0;
        end
    end

    always_comb begin
        bus.out_enq__ENA = '0;
        bus.out_enq_v    = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            bus.out_enq__ENA[j] = (r_cnt[j] != '0);
            if (r_cnt[j] != '0) bus.out_enq_v[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[j][r_rp[j]];
        end
    end

    // Destinations beyond the channel count fold back by one subtraction (field < 2*CHANNELS).
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_route[i] = bus.cfg_route_v[i*IDX_W +: IDX_W];
            if ({1'b0, w_route[i]} >= CH_W1) w_route[i] = IDX_W'({1'b0, w_route[i]} - CH_W1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (bus.pause__ENA)     w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_all_empty)        w_state_nxt = ST_IDLE;
            ST_IDLE:  if (bus.cfg_route__ENA) w_state_nxt = ST_RUN;
            default:                          w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= ST_RUN;
            r_skid_vld <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_dest[i] <= (CROSSED != 0) ? IDX_W'(CHANNELS - 1 - i) : IDX_W'(i);
                r_rr[i]   <= '0;
                r_wp[i]   <= '0;
                r_rp[i]   <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_take[i])        r_skid_vld[i] <= 1'b0;
                else if (w_accept[i]) r_skid_vld[i] <= 1'b1;
                if (r_state == ST_IDLE && bus.cfg_route__ENA) r_dest[i] <= w_route[i];
            end
            for (int j = 0; j < CHANNELS; j++) begin
                if (w_gnt_vld[j]) begin
                    r_wp[j] <= r_wp[j] + PTR_W'(1);
                    r_rr[j] <= (w_gnt_idx[j] == LAST_IDX) ? '0 : w_gnt_idx[j] + IDX_W'(1);
                end
                if (w_pop[j]) r_rp[j] <= r_rp[j] + PTR_W'(1);
                if (w_gnt_vld[j] && !w_pop[j])      r_cnt[j] <= r_cnt[j] + CNT_W'(1);
                else if (!w_gnt_vld[j] && w_pop[j]) r_cnt[j] <= r_cnt[j] - CNT_W'(1);
            end
        end
    end

    // Payload storage carries no reset; validity lives in r_skid_vld and r_cnt.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < CHANNELS; i++)
            if (w_accept[i]) r_skid_data[i] <= bus.in_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 0; j < CHANNELS; j++)
            if (w_gnt_vld[j]) r_mem[j][r_wp[j]] <= r_skid_data[w_gnt_idx[j]];
    end
endmodule

// File: tb/tb_pipe_net_n.sv
// tb/tb_pipe_net_n.sv - directed and randomized scoreboard bench for pipe_net_n
module tb_pipe_net_n;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int IW = 2;
    localparam int STARVE_BOUND = CH*DEPTH + CH;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    pipe_net_n_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .IDX_W(IW)) bus();

    pipe_net_n #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CROSSED(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct { int ch; logic [DW-1:0] d; } pop_t;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] drv_q [CH][$];
    logic [DW-1:0] exp_q [CH][$];
    pop_t          pop_log[$];
    int            acc_cnt [CH];
    int            seq [CH];
    int            dest_m [CH];
    int            starve [CH];
    int            starve_max [CH];
    int            sb_pops = 0;
    logic [CH-1:0] acc_seen;
    logic [CH-1:0] ordy_dir;
    bit            rnd_on = 0;
    bit            sb_on = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] beat(input int src, input int n);
        return {4'(src), 4'hA, 24'(n)};
    endfunction

    // Ingress driver: each ingress holds its queue head until accepted.
    initial begin
        bus.in_enq__ENA  = '0;
        bus.in_enq_v     = '0;
        bus.out_enq__RDY = '0;
        for (int i = 0; i < CH; i++) begin acc_cnt[i] = 0; seq[i] = 0; end
        forever begin
            @(negedge CLK);
            acc_seen = bus.in_enq__ENA & bus.in_enq__RDY;
            @(posedge CLK);
            #2;
            for (int i = 0; i < CH; i++) begin
                if (acc_seen[i] && drv_q[i].size() != 0) begin
                    void'(drv_q[i].pop_front());
                    acc_cnt[i]++;
                end
                if (rnd_on && drv_q[i].size() == 0 && $urandom_range(0, 9) < 6) begin
                    drv_q[i].push_back({4'(i), 28'(seq[i])});
                    seq[i]++;
                end
                bus.in_enq__ENA[i] = (drv_q[i].size() != 0);
                bus.in_enq_v[i*DW +: DW] = (drv_q[i].size() != 0) ? drv_q[i][0] : '0;
            end
            bus.out_enq__RDY = rnd_on ? 4'($urandom) : ordy_dir;
        end
    end

    // Monitor: logs egress pops, and in scoreboard mode checks route, order and starvation.
    logic [DW-1:0] mon_d;
    int            mon_src;
    always @(negedge CLK) begin
        if (sb_on)
            for (int i = 0; i < CH; i++)
                if (bus.in_enq__ENA[i] && bus.in_enq__RDY[i])
                    exp_q[i].push_back(bus.in_enq_v[i*DW +: DW]);
        for (int j = 0; j < CH; j++) begin
            if (bus.out_enq__ENA[j] && bus.out_enq__RDY[j]) begin
                mon_d = bus.out_enq_v[j*DW +: DW];
                pop_log.push_back('{j, mon_d});
                if (sb_on) begin
                    sb_pops++;
                    mon_src = int'(mon_d[31:28]);
                    if (mon_src >= CH) check("sb_src_range", 32'(mon_src), 32'(CH-1));
                    else begin
                        check("sb_route", 32'(j), 32'(dest_m[mon_src]));
                        if (exp_q[mon_src].size() == 0) check("sb_dup", mon_d, 32'hFFFF_FFFF);
                        else check("sb_order", mon_d, exp_q[mon_src].pop_front());
                    end
                end
            end
        end
        if (sb_on)
            for (int i = 0; i < CH; i++) begin
                if (!bus.in_enq__RDY[i]) begin
                    if (bus.out_enq__ENA[dest_m[i]] && bus.out_enq__RDY[dest_m[i]]) starve[i]++;
                end else starve[i] = 0;
                if (starve[i] > starve_max[i]) starve_max[i] = starve[i];
            end
    end

    task automatic reroute(input logic [CH*IW-1:0] r);
        int n;
        bus.pause__ENA = 1'b1;
        tick();
        bus.pause__ENA = 1'b0;
        n = 0;
        while (!bus.cfg_route__RDY && n < 200) begin tick(); n++; end
        check("drain_reaches_idle", 32'(bus.cfg_route__RDY), 32'd1);
        bus.cfg_route_v    = r;
        bus.cfg_route__ENA = 1'b1;
        tick();
        bus.cfg_route__ENA = 1'b0;
        for (int i = 0; i < CH; i++) dest_m[i] = int'(r[i*IW +: IW]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        logic [2:0] five;
        nRST = 1'b0;
        bus.pause__ENA = 1'b0;
        bus.cfg_route__ENA = 1'b0;
        bus.cfg_route_v = '0;
        ordy_dir = '1;
        for (int i = 0; i < CH; i++) begin dest_m[i] = CH-1-i; starve[i] = 0; starve_max[i] = 0; end
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_rdy", 32'(bus.in_enq__RDY), 32'hF);
        check("rst_out_ena", 32'(bus.out_enq__ENA), 32'h0);
        check("rst_out_v", 32'(bus.out_enq_v[127:96] | bus.out_enq_v[95:64] | bus.out_enq_v[63:32] | bus.out_enq_v[31:0]), 32'h0);
        check("rst_pause_rdy", 32'(bus.pause__RDY), 32'd1);
        check("rst_cfg_rdy", 32'(bus.cfg_route__RDY), 32'd0);
        nRST = 1'b1;
        tick();

        // Crossed reset route: in0 -> out3, in1 -> out2, two cycles after acceptance.
        drv_q[0].push_back(32'hA1);
        drv_q[1].push_back(32'hB2);
        tick();
        check("x_lat1_ena", 32'(bus.out_enq__ENA), 32'h0);
        tick();
        check("x_lat2_ena", 32'(bus.out_enq__ENA), 32'hC);
        check("x_out3", bus.out_enq_v[3*DW +: DW], 32'hA1);
        check("x_out2", bus.out_enq_v[2*DW +: DW], 32'hB2);
        repeat (3) tick();

        // All ingresses to egress 0 with egress 0 blocked.
        reroute('0);
        ordy_dir = 4'b1110;
        pop_log.delete();
        acc0 = acc_cnt[0] + acc_cnt[1] + acc_cnt[2] + acc_cnt[3];
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < CH; i++) drv_q[i].push_back(beat(i, b));
        repeat (20) tick();
        check("rr_accepted", 32'(acc_cnt[0] + acc_cnt[1] + acc_cnt[2] + acc_cnt[3] - acc0), 32'd8);
        check("rr_in_rdy_all0", 32'(bus.in_enq__RDY), 32'h0);
        check("rr_head", bus.out_enq_v[DW-1:0], beat(0, 0));
        check("rr_no_pop_blocked", 32'(pop_log.size()), 32'd0);
        ordy_dir = 4'b1111;
        tick();
        check("full_pop_no_push", 32'(bus.in_enq__RDY[0]), 32'd0);
        tick();
        check("full_push_next", 32'(bus.in_enq__RDY[0]), 32'd1);
        n = 0;
        while (pop_log.size() < 12 && n < 60) begin tick(); n++; end
        check("rr_pop_count", 32'(pop_log.size()), 32'd12);
        for (int k = 0; k < 12 && k < pop_log.size(); k++) begin
            check("rr_pop_ch", 32'(pop_log[k].ch), 32'd0);
            check("rr_pop_data", pop_log[k].d, beat(k % CH, k / CH));
        end
        repeat (3) tick();

        // Pause with 3 beats buffered, then load a folded route.
        ordy_dir = 4'b1110;
        pop_log.delete();
        for (int i = 0; i < 3; i++) drv_q[i].push_back(beat(i, 7));
        repeat (8) tick();
        bus.pause__ENA = 1'b1;
        tick();
        bus.pause__ENA = 1'b0;
        check("pause_in_rdy", 32'(bus.in_enq__RDY), 32'h0);
        check("pause_rdy_low", 32'(bus.pause__RDY), 32'd0);
        repeat (3) tick();
        check("drain_blocked_cfg", 32'(bus.cfg_route__RDY), 32'd0);
        ordy_dir = 4'b1111;
        tick();
        tick();
        check("drain_mid_cfg", 32'(bus.cfg_route__RDY), 32'd0);
        tick();
        check("drain_last_pop_cfg", 32'(bus.cfg_route__RDY), 32'd0);
        check("drain_pops", 32'(pop_log.size()), 32'd3);
        tick();
        check("idle_cfg_rdy", 32'(bus.cfg_route__RDY), 32'd1);
        for (int k = 0; k < 3 && k < pop_log.size(); k++) check("drain_order", pop_log[k].d, beat(k, 7));
        five = 3'd5;
        bus.cfg_route_v = {2'd2, 2'd3, 2'd0, five[1:0]};
        bus.cfg_route__ENA = 1'b1;
        tick();
        bus.cfg_route__ENA = 1'b0;
        dest_m[0] = 1; dest_m[1] = 0; dest_m[2] = 3; dest_m[3] = 2;
        check("cfg_reopen", 32'(bus.in_enq__RDY), 32'hF);
        drv_q[0].push_back(32'h55);
        tick();
        check("route5_lat1", 32'(bus.out_enq__ENA), 32'h0);
        tick();
        check("route5_ena", 32'(bus.out_enq__ENA), 32'h2);
        check("route5_data", bus.out_enq_v[DW +: DW], 32'h55);
        repeat (3) tick();

        // Reset while draining with 2 beats buffered.
        ordy_dir = 4'b0000;
        drv_q[0].push_back(32'h11);
        drv_q[1].push_back(32'h22);
        repeat (6) tick();
        bus.pause__ENA = 1'b1;
        tick();
        bus.pause__ENA = 1'b0;
        tick();
        check("rst_pre_drain", 32'(bus.pause__RDY), 32'd0);
        #2 nRST = 1'b0;
        #1;
        check("rst_mid_out_ena", 32'(bus.out_enq__ENA), 32'h0);
        check("rst_mid_in_rdy", 32'(bus.in_enq__RDY), 32'hF);
        check("rst_mid_pause", 32'(bus.pause__RDY), 32'd1);
        @(posedge CLK);
        #1 nRST = 1'b1;
        for (int i = 0; i < CH; i++) dest_m[i] = CH-1-i;
        ordy_dir = 4'b1111;
        pop_log.delete();
        repeat (5) tick();
        check("rst_no_stale", 32'(pop_log.size()), 32'd0);
        drv_q[0].push_back(32'h77);
        repeat (6) tick();
        check("rst_route_pops", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() != 0) begin
            check("rst_route_ch", 32'(pop_log[0].ch), 32'd3);
            check("rst_route_data", pop_log[0].d, 32'h77);
        end

        // Random traffic on a random route with random backpressure.
        reroute(8'($urandom));
        for (int i = 0; i < CH; i++) seq[i] = 0;
        sb_on = 1;
        rnd_on = 1;
        repeat (10000) tick();
        rnd_on = 0;
        ordy_dir = '1;
        n = 0;
        while (n < 500 && (drv_q[0].size() + drv_q[1].size() + drv_q[2].size() + drv_q[3].size()
                           + exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0) begin
            tick();
            n++;
        end
        repeat (4) tick();
        sb_on = 0;
        for (int i = 0; i < CH; i++) begin
            check("sb_leftover", 32'(exp_q[i].size()), 32'd0);
            check("sb_starve", 32'(starve_max[i] <= STARVE_BOUND), 32'd1);
        end
        check("sb_traffic", 32'(sb_pops > 1000), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
